// File: rtl/rr_bus_scheduler.sv
// Four-requester round-robin bus scheduler with grant hold and one-cycle turnaround.
// Optional forced release after MAX_HOLD cycles: define RR_BUS_SCHED_TIMEOUT_EN.
module rr_bus_scheduler #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  output logic [3:0] gnt_o,
  output logic [1:0] gnt_idx_o,
  output logic       gnt_valid_o,
  output logic       timeout_o
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] last_q, last_d;
  logic       win_vld;
  logic [1:0] win_idx;

`ifdef RR_BUS_SCHED_TIMEOUT_EN
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] CMAX = CW'(MAX_HOLD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
`endif

  // search starts just after the last owner and ends on it
  always_comb begin : arbiter
    logic [1:0] cand;
    cand    = '0;
    win_vld = 1'b0;
    win_idx = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_vld && req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
`ifdef RR_BUS_SCHED_TIMEOUT_EN
    cnt_d   = '0;
    to_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE, GAP: begin
        if (win_vld) begin
          state_d = GRANT;
          idx_d   = win_idx;
          last_d  = win_idx;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
`ifdef RR_BUS_SCHED_TIMEOUT_EN
        cnt_d = cnt_q + CW'(1);
        if (!req_i[idx_q]) begin
          state_d = GAP;
        end else if (cnt_q == CMAX) begin
          state_d = GAP;
          to_d    = 1'b1;
        end
`else
        if (!req_i[idx_q]) begin
          state_d = GAP;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

`ifdef RR_BUS_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout_o = to_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign gnt_valid_o = (state_q == GRANT);
  assign gnt_idx_o   = idx_q;
  assign gnt_o       = gnt_valid_o ? (4'b0001 << idx_q) : 4'b0000;

endmodule

// File: tb/tb_rr_bus_scheduler.sv
// Scoreboard bench for rr_bus_scheduler: directed req vectors, expected outputs queued.
// Timeout expectations switch on RR_BUS_SCHED_TIMEOUT_EN.
module tb_rr_bus_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  rr_bus_scheduler #(.MAX_HOLD(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .gnt_o      (gnt),
    .gnt_idx_o  (gnt_idx),
    .gnt_valid_o(gnt_valid),
    .timeout_o  (timeout)
  );

  typedef struct {
    logic [3:0] g;
    logic [1:0] i;
    logic       v;
    logic       t;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input exp_t e);
    n_vec++;
    if (gnt !== e.g || gnt_idx !== e.i ||
        gnt_valid !== e.v || timeout !== e.t) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b idx=%0d vld=%b to=%b, want gnt=%b idx=%0d vld=%b to=%b",
               e.tag, gnt, gnt_idx, gnt_valid, timeout,
               e.g, e.i, e.v, e.t);
    end
  endfunction

  task automatic push(input logic [3:0] g, input logic [1:0] i,
                      input logic v, input logic t, input string tag);
    exp_t e;
    e.g = g; e.i = i; e.v = v; e.t = t; e.tag = tag;
    sbq.push_back(e);
  endtask

  // drive req now; expect outputs after the next rising edge
  task automatic vec(input logic [3:0] r, input logic [3:0] g,
                     input logic [1:0] i, input logic v,
                     input logic t, input string tag);
    req = r;
    @(posedge clk);
    #1;
    push(g, i, v, t, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    req = 4'b0000;
    #1 push(4'b0000, 2'd0, 1'b0, 1'b0, "reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        check(e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] own;
    exp_t       e;
    rst_n = 1'b0;
    req   = 4'b0000;
    #1 push(4'b0000, 2'd0, 1'b0, 1'b0, "reset0");
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    repeat (3) vec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "idle");
    vec(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "single");
    vec(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "rel_gap");
    vec(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "rel_idle");

    do_reset();
    for (int k = 0; k < 4; k++) begin
      own = 4'b0001 << k;
      vec(4'b1111, own, 2'(k), 1'b1, 1'b0, "rr_a");
      vec(4'b1111, own, 2'(k), 1'b1, 1'b0, "rr_b");
      vec(4'b1111 & ~own, 4'b0000, 2'(k), 1'b0, 1'b0, "rr_gap");
    end
    vec(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, "rr_wrap");
    vec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_rel");
    vec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_idle");

    vec(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, "np_gnt");
    repeat (3) vec(4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0, "np_hold");
    vec(4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0, "np_gap");
    vec(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, "np_next");
    vec(4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, "np_rel");
    vec(4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, "np_idle");

    vec(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "sole_gnt");
    vec(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "sole_gap");
    vec(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "sole_idle");
    vec(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "sole_regnt");
    vec(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "sole_gap2");
    vec(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "sole_gapwin");
    vec(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "sole_gap3");
    vec(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "sole_idle3");

`ifdef RR_BUS_SCHED_TIMEOUT_EN
    repeat (8) vec(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "sole_cont");
    vec(4'b0010, 4'b0000, 2'd1, 1'b0, 1'b1, "sole_to");
    vec(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "sole_again");
    vec(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "sole_rel");
    vec(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "sole_idle4");

    repeat (8) vec(4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0, "to_hold");
    vec(4'b0011, 4'b0000, 2'd0, 1'b0, 1'b1, "to_pulse");
    vec(4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0, "to_next");
    vec(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "to_rel");
    vec(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "to_idle");
`else
    repeat (12) vec(4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0, "nto_hold");
    vec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "nto_rel");
    vec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "nto_idle");
`endif

    repeat (8) vec(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "vol_hold");
    vec(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "vol_at_max");
    vec(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "vol_idle");

    vec(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "ar_gnt");
    vec(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "ar_hold");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    e.g = 4'b0000; e.i = 2'd0; e.v = 1'b0; e.t = 1'b0;
    e.tag = "ar_immediate";
    check(e);
    push(4'b0000, 2'd0, 1'b0, 1'b0, "ar_held");
    @(negedge clk);
    #2 req = 4'b1111;
    rst_n = 1'b1;
    @(posedge clk);
    #1 push(4'b0001, 2'd0, 1'b1, 1'b0, "ar_first");
    vec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "ar_gap");
    vec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "ar_idle");

    repeat (2) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d queued, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
